// File: rtl/tree_path_walker.sv
`default_nettype none
// =============================================================================
// tree_path_walker : walks a stored message-hierarchy tree along a root-first
//                    stream of field identifiers.   Revision: 1.0
// =============================================================================
module tree_path_walker #(
    parameter int IDENTIFIER_SIZE     = 8,
    parameter int NODE_ADDR_SIZE      = 8,
    parameter int MAX_NODES_PER_LEVEL = 4,
    parameter int MAX_DEPTH           = 4,
    parameter int NODE_SIZE           = IDENTIFIER_SIZE + NODE_ADDR_SIZE*(1+MAX_NODES_PER_LEVEL)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 id_valid_i,
    output logic                                 id_ready_o,
    input  logic [IDENTIFIER_SIZE-1:0]           id_data_i,
    input  logic                                 id_last_i,
    output logic                                 mem_rd_en_o,
    output logic [NODE_ADDR_SIZE-1:0]            mem_rd_addr_o,
    input  logic [NODE_SIZE-1:0]                 mem_rd_data_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic                                 res_hit_o,
    output logic                                 res_err_o,
    output logic [NODE_ADDR_SIZE-1:0]            res_node_addr_o,
    output logic [$clog2(MAX_DEPTH+1)-1:0]       res_depth_o
);

    localparam int DW = $clog2(MAX_DEPTH+1);
    localparam int KW = $clog2(MAX_NODES_PER_LEVEL+1);
    localparam int IW = IDENTIFIER_SIZE;
    localparam int AW = NODE_ADDR_SIZE;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ROOT_RD   = 3'd1,
        S_WAIT_ID   = 3'd2,
        S_PROBE_RD  = 3'd3,
        S_PROBE_CMP = 3'd4,
        S_DRAIN     = 3'd5,
        S_RESULT    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   id_q, id_d;
    logic            last_q, last_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   cur_q, cur_d;
    logic            hit_q, hit_d;
    logic            err_q, err_d;
    logic            root_pend_q;
    logic [AW-1:0]   child_q [MAX_NODES_PER_LEVEL];
    logic [AW-1:0]   child_d [MAX_NODES_PER_LEVEL];
    logic [AW-1:0]   w_child;
    logic            w_unused_parent;

    assign w_unused_parent = ^mem_rd_data_i[NODE_SIZE-IW-1 -: AW];

    always_comb begin
        w_child = '0;
        for (int j = 0; j < MAX_NODES_PER_LEVEL; j++) begin
            if (k_q == KW'(j)) w_child = child_q[j];
        end
    end

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        last_d        = last_q;
        depth_d       = depth_q;
        k_d           = k_q;
        cur_d         = cur_q;
        hit_d         = hit_q;
        err_d         = err_q;
        child_d       = child_q;
        id_ready_o    = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;

        // Root node word arrives the cycle after ROOT_RD, i.e. during the first WAIT_ID cycle.
        if (root_pend_q) begin
            for (int j = 0; j < MAX_NODES_PER_LEVEL; j++) child_d[j] = mem_rd_data_i[j*AW +: AW];
        end

        case (state_q)
            S_IDLE: begin
                if (id_valid_i) begin
                    state_d = S_ROOT_RD;
                    cur_d   = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    depth_d = '0;
                end
            end
            S_ROOT_RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = S_WAIT_ID;
            end
            S_WAIT_ID: begin
                id_ready_o = 1'b1;
                if (id_valid_i) begin
                    id_d   = id_data_i;
                    last_d = id_last_i;
                    if (depth_q != DW'(MAX_DEPTH)) depth_d = depth_q + DW'(1);
                    if ((id_data_i == '0) || (depth_q == DW'(MAX_DEPTH))) begin
                        err_d   = 1'b1;
                        state_d = id_last_i ? S_RESULT : S_DRAIN;
                    end else begin
                        k_d     = '0;
                        state_d = S_PROBE_RD;
                    end
                end
            end
            S_PROBE_RD: begin
                if ((k_q == KW'(MAX_NODES_PER_LEVEL)) || (w_child == '0)) begin
                    state_d = last_q ? S_RESULT : S_DRAIN;
                end else begin
                    mem_rd_en_o   = 1'b1;
                    mem_rd_addr_o = w_child;
                    state_d       = S_PROBE_CMP;
                end
            end
            S_PROBE_CMP: begin
                if (mem_rd_data_i[NODE_SIZE-1 -: IW] == id_q) begin
                    cur_d = w_child;
                    for (int j = 0; j < MAX_NODES_PER_LEVEL; j++) child_d[j] = mem_rd_data_i[j*AW +: AW];
                    if (last_q) begin
                        hit_d   = 1'b1;
                        state_d = S_RESULT;
                    end else begin
                        state_d = S_WAIT_ID;
                    end
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_PROBE_RD;
                end
            end
            S_DRAIN: begin
                id_ready_o = 1'b1;
                if (id_valid_i) begin
                    if (depth_q != DW'(MAX_DEPTH)) depth_d = depth_q + DW'(1);
                    if (id_last_i) state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                    depth_d = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    cur_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            last_q      <= 1'b0;
            depth_q     <= '0;
            k_q         <= '0;
            cur_q       <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            root_pend_q <= 1'b0;
            for (int j = 0; j < MAX_NODES_PER_LEVEL; j++) child_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            last_q      <= last_d;
            depth_q     <= depth_d;
            k_q         <= k_d;
            cur_q       <= cur_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            root_pend_q <= (state_q == S_ROOT_RD);
            child_q     <= child_d;
        end
    end

    assign res_valid_o     = (state_q == S_RESULT);
    assign res_hit_o       = hit_q;
    assign res_err_o       = err_q;
    assign res_node_addr_o = hit_q ? cur_q : '0;
    assign res_depth_o     = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_path_walker.sv
`default_nettype none
// =============================================================================
// tb_tree_path_walker : directed and random paths against a path-walk model.
//                       Revision: 1.0
// =============================================================================
module tb_tree_path_walker;

    localparam int IW = 8;
    localparam int AW = 8;
    localparam int NN = 4;
    localparam int MD = 4;
    localparam int NS = IW + AW*(1+NN);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [IW-1:0] id_data = '0;
    logic          id_last = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [NS-1:0] mem_rd_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic          res_err;
    logic [AW-1:0] res_node_addr;
    logic [2:0]    res_depth;

    logic [NS-1:0] mem [256];
    int            errors = 0;
    int            checks = 0;
    int            pth [8];
    int            nodeid [64];
    int            nch [64];
    int            tch [64][4];

    tree_path_walker #(
        .IDENTIFIER_SIZE(IW), .NODE_ADDR_SIZE(AW),
        .MAX_NODES_PER_LEVEL(NN), .MAX_DEPTH(MD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_data_i(id_data), .id_last_i(id_last),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_hit_o(res_hit), .res_err_o(res_err),
        .res_node_addr_o(res_node_addr), .res_depth_o(res_depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS-1:0] mk(input int id, input int par, input int c0, input int c1,
                                         input int c2, input int c3);
        return {id[7:0], par[7:0], c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    // Path walk from the root: scan each node's filled child slots for the identifier.
    task automatic model(input int n, output bit hit, output bit err, output int addr,
                         output int depth, output int lat);
        int cur, found, s, c;
        bit miss;
        logic [NS-1:0] w;
        cur = 0; miss = 0; hit = 0; err = 0; addr = 0; depth = 0; lat = 0;
        for (int i = 0; i < n; i++) begin
            depth = (i + 1 > MD) ? MD : i + 1;
            lat = 0;
            if (miss) continue;
            if (pth[i] == 0 || i >= MD) begin
                err = 1; miss = 1;
                continue;
            end
            found = -1; s = 0;
            while (s < NN) begin
                w = mem[cur];
                c = int'(w[s*AW +: AW]);
                if (c == 0) break;
                w = mem[c];
                if (int'(w[NS-1 -: IW]) == pth[i]) begin found = c; break; end
                s++;
            end
            if (found >= 0) begin cur = found; lat = 2*(s+1); end
            else begin miss = 1; lat = 2*s + 1; end
        end
        hit = !miss;
        addr = hit ? cur : 0;
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send_id(input int id, input logic last);
        int t;
        id_valid = 1'b1; id_data = id[7:0]; id_last = last;
        t = 0;
        while (id_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("id_ready_timeout", 32'(t), 32'(0));
        @(posedge clk);
        @(negedge clk);
        id_valid = 1'b0; id_last = 1'b0;
    endtask

    task automatic run_path(input int n, input int hold, input bit chk_lat);
        bit ehit, eerr;
        int eaddr, edepth, elat, lat;
        model(n, ehit, eerr, eaddr, edepth, elat);
        for (int i = 0; i < n; i++) send_id(pth[i], i == n-1);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        if (chk_lat) chk("latency", 32'(lat), 32'(elat));
        chk("res_hit", {31'd0, res_hit}, {31'd0, ehit});
        chk("res_err", {31'd0, res_err}, {31'd0, eerr});
        chk("res_node_addr", {24'd0, res_node_addr}, 32'(eaddr));
        chk("res_depth", {29'd0, res_depth}, 32'(edepth));
        chk("id_ready_in_result", {31'd0, id_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_addr", {24'd0, res_node_addr}, 32'(eaddr));
            chk("hold_fields", {29'd0, res_hit, res_err, id_ready}, {29'd0, ehit, eerr, 1'b0});
            chk("hold_depth", {29'd0, res_depth}, 32'(edepth));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_released", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk("single_result", {31'd0, res_valid}, 32'd0);
    endtask

    task automatic outputs_zero(input string tag);
        chk(tag, {20'd0, id_ready, mem_rd_en, res_valid, res_hit, res_err, res_depth, 5'd0},
            32'd0);
        chk(tag, {16'd0, mem_rd_addr, res_node_addr}, 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[0] = mk(0, 0, 1, 0, 0, 0);
        mem[1] = mk(5, 0, 2, 3, 0, 0);
        mem[2] = mk(7, 1, 0, 0, 0, 0);
        mem[3] = mk(9, 1, 5, 0, 0, 0);
        mem[5] = mk(11, 3, 6, 0, 0, 0);
        mem[6] = mk(13, 5, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        outputs_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        pth = '{5, 9, 0, 0, 0, 0, 0, 0};   run_path(2, 0, 1);
        pth = '{5, 8, 0, 0, 0, 0, 0, 0};   run_path(2, 0, 1);
        pth = '{6, 7, 9, 0, 0, 0, 0, 0};   run_path(3, 0, 1);
        pth = '{5, 9, 11, 13, 7, 0, 0, 0}; run_path(5, 0, 1);
        pth = '{5, 9, 11, 13, 0, 0, 0, 0}; run_path(4, 0, 1);
        pth = '{5, 7, 0, 0, 0, 0, 0, 0};   run_path(2, 10, 1);
        pth = '{5, 0, 0, 0, 0, 0, 0, 0};   run_path(1, 0, 1);
        pth = '{0, 0, 0, 0, 0, 0, 0, 0};   run_path(1, 0, 1);
        pth = '{5, 0, 7, 0, 0, 0, 0, 0};   run_path(3, 0, 1);
        pth = '{5, 9, 11, 0, 0, 0, 0, 0};  run_path(3, 0, 1);

        // Asynchronous reset while comparing the first probed child.
        send_id(5, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_depth", {29'd0, res_depth}, 32'd1);
        rst_n = 1'b0;
        #1;
        outputs_zero("reset_in_probe_cmp");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pth = '{5, 9, 0, 0, 0, 0, 0, 0};   run_path(2, 0, 1);

        // Random trees and paths.
        for (int tr = 0; tr < 3; tr++) begin
            for (int a = 0; a < 64; a++) begin
                nch[a] = 0; nodeid[a] = 0;
                for (int s = 0; s < 4; s++) tch[a][s] = 0;
            end
            for (int a = 1; a < 24; a++) begin
                int p;
                p = $urandom_range(0, a-1);
                if (nch[p] >= 4) p = a - 1;
                nodeid[a] = $urandom_range(1, 6);
                tch[p][nch[p]] = a;
                nch[p]++;
            end
            for (int a = 0; a < 256; a++) mem[a] = '0;
            for (int a = 0; a < 24; a++)
                mem[a] = mk(nodeid[a], 0, tch[a][0], tch[a][1], tch[a][2], tch[a][3]);
            for (int r = 0; r < 12; r++) begin
                int cur, len;
                cur = 0;
                len = $urandom_range(1, 4);
                for (int i = 0; i < 8; i++) pth[i] = 0;
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 3) != 0 && nch[cur] > 0) begin
                        int c;
                        c = tch[cur][$urandom_range(0, nch[cur]-1)];
                        pth[i] = nodeid[c];
                        cur = c;
                    end else begin
                        pth[i] = $urandom_range(1, 7);
                    end
                end
                run_path(len, $urandom_range(0, 2), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
